// File: rtl/dmem_pkg.sv
// Shared types and constants for the latency-configurable data memory.
package dmem_pkg;

  // Supported access latency range, in clock cycles.
  localparam int unsigned LATENCY_MIN = 1;
  localparam int unsigned LATENCY_MAX = 4;

  // Width of the latency down-counter (holds LATENCY_MAX-1).
  localparam int unsigned CNT_W = 2;

  typedef enum logic {
    StIdle,
    StBusy
  } state_e;

  typedef enum logic {
    OpRd,
    OpWr
  } op_e;

  // Counter preload value for a given latency: the access completes when the
  // counter reaches 1, i.e. LATENCY-1 edges after acceptance.
  function automatic logic [CNT_W-1:0] lat_load(int unsigned lat);
    return CNT_W'(lat - 1);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH x DATA_W storage with synchronous byte-lane writes and a registered
// read port. The storage itself is never reset; only the read register is.
module dmem_array #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned DEPTH    = 256,
  localparam int unsigned IdxW    = $clog2(DEPTH),
  localparam int unsigned NumBytes = DATA_W / 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en_i,
  input  logic                rd_en_i,
  input  logic                rd_clr_i,
  input  logic [IdxW-1:0]     idx_i,
  input  logic [DATA_W-1:0]   wdata_i,
  input  logic [NumBytes-1:0] be_i,
  output logic [DATA_W-1:0]   rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Byte-lane write into storage; no reset so preloaded contents survive.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      for (int unsigned b = 0; b < NumBytes; b++) begin
        if (be_i[b]) begin
          mem_q[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  // Read register: loads the addressed word, or zero for an out-of-range read,
  // and otherwise holds its last value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (rd_clr_i) begin
      rdata_q <= '0;
    end else if (rd_en_i) begin
      rdata_q <= mem_q[idx_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmemory_lat.sv
// Latency-configurable data memory for the CPU MEM stage. Accepts one
// request at a time, stalls the CPU via mem_ready for multi-cycle latencies,
// supports byte-enable writes and flags out-of-range or conflicting requests.
module dmemory_lat #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned LATENCY = 1,
  localparam int unsigned IdxW     = $clog2(DEPTH),
  localparam int unsigned NumBytes = DATA_W / 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                MemRead,
  input  logic                MemWrite,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   Write_data,
  input  logic [NumBytes-1:0] byte_en,
  output logic [DATA_W-1:0]   Read_data,
  output logic                rd_valid,
  output logic                mem_ready,
  output logic                err
);

  import dmem_pkg::*;

  if (LATENCY < LATENCY_MIN || LATENCY > LATENCY_MAX) begin : g_bad_latency
    $error("dmemory_lat: LATENCY out of range");
  end
  if ((DATA_W % 8) != 0) begin : g_bad_width
    $error("dmemory_lat: DATA_W must be a multiple of 8");
  end

  // With unit latency the access completes on the accepting edge itself, so
  // the live bus is used instead of the capture registers.
  localparam bit SingleCycle = (LATENCY == 1);

  // One extra bit so DEPTH == 2**ADDR_W is representable.
  localparam logic [ADDR_W:0] DepthLimit = (ADDR_W + 1)'(DEPTH);

  state_e                state_q;
  logic [CNT_W-1:0]      cnt_q;
  op_e                   op_q;
  logic [IdxW-1:0]       idx_q;
  logic [DATA_W-1:0]     wdata_q;
  logic [NumBytes-1:0]   be_q;
  logic                  oor_q;
  logic                  rd_valid_q;
  logic                  err_q;
  logic                  ready_q;

  logic                  idle;
  logic                  req_one;
  logic                  req_both;
  logic                  accept;
  logic                  addr_oor;
  op_e                   req_op;

  logic                  complete;
  op_e                   cmp_op;
  logic [IdxW-1:0]       cmp_idx;
  logic [DATA_W-1:0]     cmp_wdata;
  logic [NumBytes-1:0]   cmp_be;
  logic                  cmp_oor;

  logic                  arr_wr_en;
  logic                  arr_rd_en;
  logic                  arr_rd_clr;

  assign idle     = (state_q == StIdle);
  assign req_one  = MemRead ^ MemWrite;
  assign req_both = MemRead & MemWrite;
  // Gate on rst so a request sitting on the bus during reset never commits.
  assign accept   = idle & req_one & ~rst;
  assign addr_oor = ({1'b0, addr} >= DepthLimit);
  assign req_op   = MemWrite ? OpWr : OpRd;

  // Select the access that completes on this edge: live bus for unit latency,
  // captured request when the counter is about to expire otherwise.
  always_comb begin
    complete  = 1'b0;
    cmp_op    = op_q;
    cmp_idx   = idx_q;
    cmp_wdata = wdata_q;
    cmp_be    = be_q;
    cmp_oor   = oor_q;
    if (SingleCycle) begin
      complete  = accept;
      cmp_op    = req_op;
      cmp_idx   = addr[IdxW-1:0];
      cmp_wdata = Write_data;
      cmp_be    = byte_en;
      cmp_oor   = addr_oor;
    end else begin
      complete  = (state_q == StBusy) && (cnt_q == CNT_W'(1));
    end
  end

  assign arr_wr_en  = complete & (cmp_op == OpWr) & ~cmp_oor;
  assign arr_rd_en  = complete & (cmp_op == OpRd) & ~cmp_oor;
  assign arr_rd_clr = complete & (cmp_op == OpRd) & cmp_oor;

  // Control FSM with latency counter, request capture and registered flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      op_q       <= OpRd;
      idx_q      <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      oor_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      err_q      <= 1'b0;
      ready_q    <= 1'b1;
    end else begin
      rd_valid_q <= complete & (cmp_op == OpRd);
      err_q      <= (complete & cmp_oor) | (idle & req_both);
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            op_q    <= req_op;
            idx_q   <= addr[IdxW-1:0];
            wdata_q <= Write_data;
            be_q    <= byte_en;
            oor_q   <= addr_oor;
            if (!SingleCycle) begin
              state_q <= StBusy;
              cnt_q   <= lat_load(LATENCY);
              ready_q <= 1'b0;
            end
          end
        end
        StBusy: begin
          // Bus inputs are ignored here; the CPU is stalled.
          cnt_q <= cnt_q - CNT_W'(1);
          if (complete) begin
            state_q <= StIdle;
            ready_q <= 1'b1;
          end
        end
      endcase
    end
  end

  dmem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk      (clk),
    .rst      (rst),
    .wr_en_i  (arr_wr_en),
    .rd_en_i  (arr_rd_en),
    .rd_clr_i (arr_rd_clr),
    .idx_i    (cmp_idx),
    .wdata_i  (cmp_wdata),
    .be_i     (cmp_be),
    .rdata_o  (Read_data)
  );

  assign rd_valid  = rd_valid_q;
  assign err       = err_q;
  assign mem_ready = ready_q;

endmodule

// File: tb/tb_dmemory_lat.sv
// Bench for dmemory_lat: three instances (latency 1, 3, 4) exercised with a
// directed vector table, hand-written corner sequences and random accesses
// checked against a word-array reference model.
module tb_dmemory_lat;

  localparam int ND    = 3;
  localparam int DEPTH = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst       [ND];
  logic        mem_read  [ND];
  logic        mem_write [ND];
  logic [15:0] addr      [ND];
  logic [15:0] wdata     [ND];
  logic [1:0]  be        [ND];
  logic [15:0] rdata     [ND];
  logic        rd_valid  [ND];
  logic        mem_ready [ND];
  logic        err       [ND];

  for (genvar g = 0; g < ND; g++) begin : g_dut
    dmemory_lat #(
      .DATA_W  (16),
      .ADDR_W  (16),
      .DEPTH   (256),
      .LATENCY (g == 0 ? 1 : (g == 1 ? 3 : 4))
    ) u_dut (
      .clk        (clk),
      .rst        (rst[g]),
      .MemRead    (mem_read[g]),
      .MemWrite   (mem_write[g]),
      .addr       (addr[g]),
      .Write_data (wdata[g]),
      .byte_en    (be[g]),
      .Read_data  (rdata[g]),
      .rd_valid   (rd_valid[g]),
      .mem_ready  (mem_ready[g]),
      .err        (err[g])
    );
  end

  // Reference model: plain word array per instance plus the last read value.
  logic [15:0] model_mem [ND][DEPTH];
  logic [15:0] exp_hold  [ND];

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    bit          rd;
    int unsigned a;
    logic [15:0] data;
    logic [1:0]  b;
    bit          hold;
    logic [15:0] exp_rd;
    bit          exp_err;
  } vec_t;

  vec_t vecs [15];

  function automatic int lat_of(int d);
    return (d == 0) ? 1 : ((d == 1) ? 3 : 4);
  endfunction

  task automatic check(input string name, input int d, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s dut%0d (lat %0d) t=%0t: got %0h expected %0h",
               name, d, lat_of(d), $time, act, exp);
    end
  endtask

  task automatic model_write(input int d, input int unsigned a, input logic [15:0] data,
                             input logic [1:0] b);
    if (a < DEPTH) begin
      for (int i = 0; i < 2; i++) begin
        if (b[i]) model_mem[d][a][8*i +: 8] = data[8*i +: 8];
      end
    end
  endtask

  // One complete access: drive, watch every cycle until completion, then one
  // more idle cycle to confirm a held request is not re-accepted.
  task automatic access(input int d, input bit rd, input int unsigned a,
                        input logic [15:0] data, input logic [1:0] b, input bit hold,
                        input logic [15:0] exp_rd, input bit exp_err);
    int lat;
    lat = lat_of(d);
    @(negedge clk);
    check("ready_before", d, 32'(mem_ready[d]), 1);
    mem_read[d]  = rd;
    mem_write[d] = !rd;
    addr[d]      = 16'(a);
    wdata[d]     = data;
    be[d]        = b;
    for (int c = 0; c < lat; c++) begin
      @(negedge clk);
      if (c == lat - 1) begin
        if (rd) exp_hold[d] = exp_rd;
        check("ready_done", d, 32'(mem_ready[d]), 1);
        check("rd_valid_done", d, 32'(rd_valid[d]), 32'(rd));
        check("err_done", d, 32'(err[d]), 32'(exp_err));
      end else begin
        check("ready_busy", d, 32'(mem_ready[d]), 0);
        check("rd_valid_busy", d, 32'(rd_valid[d]), 0);
        check("err_busy", d, 32'(err[d]), 0);
      end
      check("read_data", d, 32'(rdata[d]), 32'(exp_hold[d]));
      if (!hold || c == lat - 1) begin
        mem_read[d]  = 1'b0;
        mem_write[d] = 1'b0;
      end
    end
    @(negedge clk);
    check("ready_after", d, 32'(mem_ready[d]), 1);
    check("rd_valid_after", d, 32'(rd_valid[d]), 0);
    check("err_after", d, 32'(err[d]), 0);
    check("read_data_after", d, 32'(rdata[d]), 32'(exp_hold[d]));
  endtask

  // Access whose expectation comes from the reference model.
  task automatic model_access(input int d, input bit rd, input int unsigned a,
                              input logic [15:0] data, input logic [1:0] b, input bit hold);
    bit          oor;
    logic [15:0] e;
    oor = (a >= DEPTH);
    e   = 16'h0;
    if (rd && !oor) e = model_mem[d][a];
    access(d, rd, a, data, b, hold, e, oor);
    if (!rd) model_write(d, a, data, b);
  endtask

  // Both MemRead and MemWrite high while idle.
  task automatic conflict(input int d);
    @(negedge clk);
    check("ready_before_conf", d, 32'(mem_ready[d]), 1);
    mem_read[d]  = 1'b1;
    mem_write[d] = 1'b1;
    addr[d]      = 16'd5;
    wdata[d]     = 16'hDEAD;
    be[d]        = 2'b11;
    @(negedge clk);
    check("err_conf", d, 32'(err[d]), 1);
    check("ready_conf", d, 32'(mem_ready[d]), 1);
    check("rd_valid_conf", d, 32'(rd_valid[d]), 0);
    check("read_data_conf", d, 32'(rdata[d]), 32'(exp_hold[d]));
    mem_read[d]  = 1'b0;
    mem_write[d] = 1'b0;
    @(negedge clk);
    check("err_conf_after", d, 32'(err[d]), 0);
    check("ready_conf_after", d, 32'(mem_ready[d]), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{rd: 0, a: 5,   data: 16'hBEEF, b: 2'b11, hold: 0, exp_rd: 16'h0,    exp_err: 0};
    vecs[1]  = '{rd: 1, a: 5,   data: 16'h0,    b: 2'b00, hold: 0, exp_rd: 16'hBEEF, exp_err: 0};
    vecs[2]  = '{rd: 0, a: 10,  data: 16'h1234, b: 2'b11, hold: 0, exp_rd: 16'h0,    exp_err: 0};
    vecs[3]  = '{rd: 1, a: 10,  data: 16'h0,    b: 2'b00, hold: 1, exp_rd: 16'h1234, exp_err: 0};
    vecs[4]  = '{rd: 0, a: 3,   data: 16'hAAAA, b: 2'b11, hold: 0, exp_rd: 16'h0,    exp_err: 0};
    vecs[5]  = '{rd: 0, a: 3,   data: 16'h5555, b: 2'b01, hold: 1, exp_rd: 16'h0,    exp_err: 0};
    vecs[6]  = '{rd: 1, a: 3,   data: 16'h0,    b: 2'b00, hold: 0, exp_rd: 16'hAA55, exp_err: 0};
    vecs[7]  = '{rd: 0, a: 3,   data: 16'h1234, b: 2'b00, hold: 0, exp_rd: 16'h0,    exp_err: 0};
    vecs[8]  = '{rd: 1, a: 3,   data: 16'h0,    b: 2'b00, hold: 0, exp_rd: 16'hAA55, exp_err: 0};
    vecs[9]  = '{rd: 0, a: 44,  data: 16'h4444, b: 2'b11, hold: 0, exp_rd: 16'h0,    exp_err: 0};
    vecs[10] = '{rd: 0, a: 300, data: 16'h0F0F, b: 2'b11, hold: 0, exp_rd: 16'h0,    exp_err: 1};
    vecs[11] = '{rd: 1, a: 44,  data: 16'h0,    b: 2'b00, hold: 0, exp_rd: 16'h4444, exp_err: 0};
    vecs[12] = '{rd: 1, a: 300, data: 16'h0,    b: 2'b00, hold: 1, exp_rd: 16'h0,    exp_err: 1};
    vecs[13] = '{rd: 0, a: 7,   data: 16'h0001, b: 2'b11, hold: 0, exp_rd: 16'h0,    exp_err: 0};
    vecs[14] = '{rd: 1, a: 7,   data: 16'h0,    b: 2'b00, hold: 0, exp_rd: 16'h0001, exp_err: 0};

    for (int d = 0; d < ND; d++) begin
      rst[d]       = 1'b1;
      mem_read[d]  = 1'b0;
      mem_write[d] = 1'b0;
      addr[d]      = '0;
      wdata[d]     = '0;
      be[d]        = '0;
      exp_hold[d]  = 16'h0;
    end

    // Reset values.
    repeat (2) @(negedge clk);
    for (int d = 0; d < ND; d++) begin
      check("reset_read_data", d, 32'(rdata[d]), 0);
      check("reset_rd_valid", d, 32'(rd_valid[d]), 0);
      check("reset_ready", d, 32'(mem_ready[d]), 1);
      check("reset_err", d, 32'(err[d]), 0);
      rst[d] = 1'b0;
    end

    // Fill every word with known random data so the model is complete.
    for (int d = 0; d < ND; d++) begin
      for (int a = 0; a < DEPTH; a++) begin
        model_access(d, 0, a, 16'($urandom), 2'b11, 0);
      end
    end

    // Directed vectors on every latency.
    for (int d = 0; d < ND; d++) begin
      for (int i = 0; i < 15; i++) begin
        access(d, vecs[i].rd, vecs[i].a, vecs[i].data, vecs[i].b, vecs[i].hold,
               vecs[i].exp_rd, vecs[i].exp_err);
        if (!vecs[i].rd) model_write(d, vecs[i].a, vecs[i].data, vecs[i].b);
      end
      conflict(d);
      // The conflicting DEAD write must not have landed.
      model_access(d, 1, 5, 16'h0, 2'b00, 0);
    end

    // Random accesses against the model.
    for (int d = 0; d < ND; d++) begin
      for (int n = 0; n < 200; n++) begin
        int unsigned a;
        if ($urandom_range(0, 9) == 0) begin
          conflict(d);
        end else begin
          a = ($urandom_range(0, 7) == 0) ? $urandom_range(256, 65535) : $urandom_range(0, 255);
          model_access(d, 1'($urandom), a, 16'($urandom), 2'($urandom), 1'($urandom));
        end
      end
    end

    // Latency 4: write aborted by reset one edge after acceptance.
    model_access(2, 0, 7, 16'h0001, 2'b11, 0);
    @(negedge clk);
    mem_write[2] = 1'b1;
    addr[2]      = 16'd7;
    wdata[2]     = 16'hFFFF;
    be[2]        = 2'b11;
    @(negedge clk);
    check("abort_wr_busy", 2, 32'(mem_ready[2]), 0);
    mem_write[2] = 1'b0;
    #1 rst[2] = 1'b1;
    #1;
    exp_hold[2] = 16'h0;
    check("abort_wr_ready", 2, 32'(mem_ready[2]), 1);
    check("abort_wr_read_data", 2, 32'(rdata[2]), 0);
    check("abort_wr_rd_valid", 2, 32'(rd_valid[2]), 0);
    check("abort_wr_err", 2, 32'(err[2]), 0);
    repeat (3) @(negedge clk);
    rst[2] = 1'b0;
    access(2, 1, 7, 16'h0, 2'b00, 0, 16'h0001, 0);

    // Latency 3: read aborted by reset must never pulse rd_valid.
    @(negedge clk);
    mem_read[1] = 1'b1;
    addr[1]     = 16'd10;
    @(negedge clk);
    check("abort_rd_busy", 1, 32'(mem_ready[1]), 0);
    mem_read[1] = 1'b0;
    #1 rst[1] = 1'b1;
    #1;
    exp_hold[1] = 16'h0;
    check("abort_rd_read_data", 1, 32'(rdata[1]), 0);
    @(negedge clk);
    rst[1] = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("abort_rd_no_valid", 1, 32'(rd_valid[1]), 0);
      check("abort_rd_ready", 1, 32'(mem_ready[1]), 1);
      check("abort_rd_held_data", 1, 32'(rdata[1]), 0);
    end
    model_access(1, 1, 10, 16'h0, 2'b00, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dmemory_lat.md
Name: dmemory_lat

Overview:
- Parametrised next-generation data memory for the pipelined CPU; replaces the fixed single-cycle data memory.
- Adds configurable data width and depth, programmable access latency with a ready/stall handshake, byte-enable writes, and an out-of-range error flag.
- Sits on the CPU MEM-stage bus (MemRead/MemWrite/addr/Write_data/Read_data). Benches may preload the array hierarchically during reset.

Parameters:
- DATA_W, 16, data word width in bits; must be a multiple of 8.
- ADDR_W, 16, address bus width (word address).
- DEPTH, 256, number of words; power of two, at most 2^ADDR_W.
- LATENCY, 1, access latency in cycles; legal range 1..4.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- MemRead  in  1  read request.
- MemWrite  in  1  write request.
- addr  in  ADDR_W  word address.
- Write_data  in  DATA_W  write data.
- byte_en  in  DATA_W/8  per-byte write enable; bit i covers bits [8i+7:8i].
- Read_data  out  DATA_W  registered read data; held until the next read completes.
- rd_valid  out  1  one-cycle pulse when Read_data updates.
- mem_ready  out  1  high = idle and able to accept a request; CPU stalls while low.
- err  out  1  one-cycle pulse on an illegal request.

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous, active-high (rst).
- Reset values: Read_data=0, rd_valid=0, err=0, mem_ready=1, state=IDLE, counter=0.
- Reset does not clear the storage array, so preloaded contents survive reset.
- FSM states: IDLE and BUSY.
- Acceptance: a request is accepted at rising edge k when state=IDLE and exactly one of MemRead/MemWrite is high.
  - addr, Write_data, byte_en and the operation are captured at edge k.
- LATENCY=1:
  - A read updates Read_data and pulses rd_valid at edge k.
  - A write commits at edge k.
  - mem_ready stays high; back-to-back accesses are allowed every cycle.
- LATENCY=L>1:
  - Edge k: IDLE->BUSY, counter loaded with L-1, mem_ready goes low after edge k.
  - Counter decrements on each edge. At edge k+L-1 the access completes: read data/rd_valid or write commit, BUSY->IDLE, mem_ready high.
  - Throughput is one access per L cycles.
- Inputs are ignored while BUSY. The CPU holds its request while stalled; the block does not re-accept it.
- Word index is addr[log2(DEPTH)-1:0].
- Out of range (addr >= DEPTH):
  - Request is still accepted and takes the full latency.
  - err pulses at the completion edge.
  - Write is suppressed; a read returns Read_data=0 with rd_valid=1.
- MemRead and MemWrite both high in IDLE:
  - err pulses at the next edge; nothing is accepted; state stays IDLE; Read_data is unchanged.
- byte_en=0 on a write: legal no-op. It takes the full latency, array is unchanged, err=0.
- Read-after-write: a read accepted after a write's completion edge returns the new data. There is no bypass requirement, because accesses never overlap.
- Reset mid-operation: a pending access is aborted.
  - A BUSY write is not committed.
  - A BUSY read produces no rd_valid.
  - All outputs return to reset values immediately (asynchronously).
- rd_valid and err are never high for more than one consecutive cycle per access.

Decomposition:
- Package dmem_pkg:
  - state enum {IDLE, BUSY}
  - LATENCY_MIN=1, LATENCY_MAX=4
  - counter width constant CNT_W=2
  - op encoding {OP_RD, OP_WR}
- Sub-module dmem_array: DEPTH x DATA_W storage with synchronous byte-enable write and registered read, instantiated once.
- Top-level dmemory_lat holds the FSM, latency counter, capture registers and range/error checks.

Test Plan:
- LATENCY=1: write 16'hBEEF to addr 5 with byte_en=2'b11, next cycle read addr 5 -> Read_data=16'hBEEF with rd_valid one cycle; mem_ready stays high throughout.
- LATENCY=3: preload mem[10]=16'h1234, read addr 10 at edge k -> mem_ready low for 2 cycles, Read_data=16'h1234 and rd_valid at edge k+2, mem_ready high afterwards; a read request held during BUSY is accepted exactly once.
- Byte enable: mem[3]=16'hAAAA, write 16'h5555 with byte_en=2'b01 -> read gives 16'hAA55. Then write with byte_en=2'b00 -> read still gives 16'hAA55, err=0.
- DEPTH=256: write 16'h0F0F to addr 300 -> err pulse at completion, mem[300 mod 256=44] unchanged. Read addr 300 -> Read_data=0, rd_valid=1, err=1.
- MemRead=MemWrite=1 in IDLE -> err pulses one cycle, no state change, Read_data unchanged.
- LATENCY=4: write 16'hFFFF to addr 7 (previously 16'h0001), assert rst at edge k+1 -> outputs return to reset values; after release, read addr 7 -> 16'h0001.
